// File: rtl/mod_mul_pkg.sv
// Shared types and the single modular add step used by the interleaved modular multiplier.
package mod_mul_pkg;

    // Widest operand the shared step function supports; wider instances are rejected at elaboration.
    localparam int MAX_W = 1024;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // (y + (a_bit ? b : 0)) mod m, valid while y < m and b < m.
    function automatic word_t mod_add_step(input word_t y, input word_t b, input word_t m,
                                           input logic a_bit);
        logic [MAX_W:0] s;
        s = {1'b0, y} + (a_bit ? {1'b0, b} : '0);
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/mod_mul_il_digit.sv
// Combinational chain of DIGIT interleaved bit-steps, LSB of the digit first.
module mod_mul_il_digit
    import mod_mul_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int DIGIT = 4
) (
    input  logic [NBITS-1:0] y_acc,
    input  logic [NBITS-1:0] b_r,
    input  logic [NBITS-1:0] m_r,
    input  logic [DIGIT-1:0] a_dig,
    output logic [NBITS-1:0] y_acc_next,
    output logic [NBITS-1:0] b_r_next
);

    logic [NBITS-1:0] y_t;
    logic [NBITS-1:0] b_t;

    // NOTE: blocking assignments chain the steps within one evaluation; both temporaries get a
    // value before the loop so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        y_t = y_acc;
        b_t = b_r;
        for (int i = 0; i < DIGIT; i++) begin
            y_t = NBITS'(mod_add_step(word_t'(y_t), word_t'(b_t), word_t'(m_r), a_dig[i]));
            b_t = NBITS'(mod_add_step(word_t'(b_t), word_t'(b_t), word_t'(m_r), 1'b1));
        end
    end

    assign y_acc_next = y_t;
    assign b_r_next   = b_t;

endmodule

// File: rtl/mod_mul_il_radix.sv
// Interleaved radix-2^DIGIT modular multiplier y = (a*b) mod m with start/busy/done handshake.
module mod_mul_il_radix
    import mod_mul_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p,
    output logic             err
);

    if (DIGIT < 1 || DIGIT > NBITS || (NBITS % DIGIT) != 0 || NBITS > MAX_W) begin : g_bad_params
        $error("mod_mul_il_radix: need 1 <= DIGIT <= NBITS <= MAX_W and DIGIT dividing NBITS");
    end

    state_e           state_q;
    logic [NBITS-1:0] a_q, b_q, m_q, y_acc_q, y_q;
    logic             busy_q, done_q, err_q;
    logic [NBITS-1:0] a_d, b_d, y_acc_d;

    assign a_d = a_q >> DIGIT;

    mod_mul_il_digit #(
        .NBITS(NBITS),
        .DIGIT(DIGIT)
    ) u_digit (
        .y_acc     (y_acc_q),
        .b_r       (b_q),
        .m_r       (m_q),
        .a_dig     (a_q[DIGIT-1:0]),
        .y_acc_next(y_acc_d),
        .b_r_next  (b_d)
    );

    // NOTE: every register here is updated with <= so all reads in this block see the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            y_acc_q <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_p) begin
                        a_q     <= a;
                        b_q     <= b;
                        m_q     <= m;
                        y_acc_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CHECK: begin
                    // y and err move only on entry to DONE, so a valid op keeps the old err through RUN.
                    if (m_q == '0 || b_q >= m_q) begin
                        err_q   <= 1'b1;
                        y_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (a_q == '0) begin
                        err_q   <= 1'b0;
                        y_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    y_acc_q <= y_acc_d;
                    b_q     <= b_d;
                    a_q     <= a_d;
                    if (a_d == '0) begin
                        y_q     <= y_acc_d;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign y          = y_q;
    assign busy       = busy_q;
    assign done_irq_p = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mod_mul_il_radix.sv
// Self-checking bench: five instances (8-bit DIGIT 2/1, 256-bit DIGIT 1/4/8) against a cycle-level model.
module tb_mod_mul_il_radix;

    localparam int NI = 5;

    typedef struct packed {
        logic [255:0] y;
        logic         err;
        logic [15:0]  k;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_a [NI];
    logic [255:0] op_a [NI];
    logic [255:0] op_b [NI];
    logic [255:0] op_m [NI];
    logic         busy_a [NI];
    logic         done_a [NI];
    logic         err_a [NI];
    logic [7:0]   y8_0, y8_1;
    logic [255:0] y256_2, y256_3, y256_4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mod_mul_il_radix #(.NBITS(8), .DIGIT(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start_p(start_a[0]),
        .a(op_a[0][7:0]), .b(op_b[0][7:0]), .m(op_m[0][7:0]),
        .y(y8_0), .busy(busy_a[0]), .done_irq_p(done_a[0]), .err(err_a[0])
    );
    mod_mul_il_radix #(.NBITS(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start_p(start_a[1]),
        .a(op_a[1][7:0]), .b(op_b[1][7:0]), .m(op_m[1][7:0]),
        .y(y8_1), .busy(busy_a[1]), .done_irq_p(done_a[1]), .err(err_a[1])
    );
    mod_mul_il_radix #(.NBITS(256), .DIGIT(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start_p(start_a[2]),
        .a(op_a[2]), .b(op_b[2]), .m(op_m[2]),
        .y(y256_2), .busy(busy_a[2]), .done_irq_p(done_a[2]), .err(err_a[2])
    );
    mod_mul_il_radix #(.NBITS(256), .DIGIT(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start_p(start_a[3]),
        .a(op_a[3]), .b(op_b[3]), .m(op_m[3]),
        .y(y256_3), .busy(busy_a[3]), .done_irq_p(done_a[3]), .err(err_a[3])
    );
    mod_mul_il_radix #(.NBITS(256), .DIGIT(8)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start_p(start_a[4]),
        .a(op_a[4]), .b(op_b[4]), .m(op_m[4]),
        .y(y256_4), .busy(busy_a[4]), .done_irq_p(done_a[4]), .err(err_a[4])
    );

    function automatic int inst_nb(input int i);
        return (i < 2) ? 8 : 256;
    endfunction

    function automatic int inst_dg(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 1;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [255:0] dut_y(input int i);
        case (i)
            0:       return {248'b0, y8_0};
            1:       return {248'b0, y8_1};
            2:       return y256_2;
            3:       return y256_3;
            default: return y256_4;
        endcase
    endfunction

    // Reference: plain (a*b) mod m, operand check, and k from a's highest nonzero digit.
    function automatic res_t ref_op(input logic [255:0] a_in, input logic [255:0] b_in,
                                    input logic [255:0] m_in, input int nb, input int dg);
        res_t         r;
        logic [255:0] msk, dmsk, a_v, b_v, m_v;
        logic [511:0] p;
        msk  = (nb >= 256) ? '1 : ((256'(1) << nb) - 256'(1));
        a_v  = a_in & msk;
        b_v  = b_in & msk;
        m_v  = m_in & msk;
        r.y  = '0;
        r.err = 1'b0;
        r.k  = '0;
        if (m_v == '0 || b_v >= m_v) begin
            r.err = 1'b1;
            return r;
        end
        p    = {256'b0, a_v} * {256'b0, b_v};
        p    = p % {256'b0, m_v};
        r.y  = p[255:0];
        dmsk = (256'(1) << dg) - 256'(1);
        for (int j = 0; j < nb / dg; j++) begin
            if (((a_v >> (j * dg)) & dmsk) != '0) r.k = 16'(j + 1);
        end
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: accepted op's start cycle, done cycle and result; results before done show old values.
    int           m_start_c [NI];
    int           m_done_c [NI];
    bit           m_act [NI];
    logic [255:0] m_y_old [NI];
    logic [255:0] m_y_new [NI];
    logic         m_err_old [NI];
    logic         m_err_new [NI];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin : model
        res_t r;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_act[i]     <= 1'b0;
                m_start_c[i] <= 0;
                m_done_c[i]  <= 0;
                m_y_old[i]   <= '0;
                m_y_new[i]   <= '0;
                m_err_old[i] <= 1'b0;
                m_err_new[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (start_a[i] === 1'b1 &&
                    !(m_act[i] && cyc > m_start_c[i] && cyc < m_done_c[i])) begin
                    r = ref_op(op_a[i], op_b[i], op_m[i], inst_nb(i), inst_dg(i));
                    m_act[i]     <= 1'b1;
                    m_start_c[i] <= cyc;
                    m_done_c[i]  <= cyc + 2 + int'(r.k);
                    m_y_old[i]   <= m_y_new[i];
                    m_err_old[i] <= m_err_new[i];
                    m_y_new[i]   <= r.y;
                    m_err_new[i] <= r.err;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                bit fin;
                bit exp_busy;
                fin      = m_act[i] && cyc >= m_done_c[i];
                exp_busy = m_act[i] && cyc > m_start_c[i] && cyc < m_done_c[i];
                check($sformatf("busy[%0d]", i), 256'(busy_a[i]), 256'(exp_busy));
                check($sformatf("done[%0d]", i), 256'(done_a[i]),
                      256'(m_act[i] && cyc == m_done_c[i]));
                check($sformatf("y[%0d]", i), dut_y(i), fin ? m_y_new[i] : m_y_old[i]);
                check($sformatf("err[%0d]", i), 256'(err_a[i]),
                      256'(fin ? m_err_new[i] : m_err_old[i]));
            end
        end
    end

    // Pulse start (immediately when b2b, i.e. in the current DONE cycle) and wait for done.
    task automatic run_op(input int i, input logic [255:0] av, input logic [255:0] bv,
                          input logic [255:0] mv, input bit b2b, input logic [255:0] ey,
                          input logic ee, input int elat);
        int lat;
        if (!b2b) @(negedge clk);
        op_a[i]    = av;
        op_b[i]    = bv;
        op_m[i]    = mv;
        start_a[i] = 1'b1;
        @(negedge clk);
        start_a[i] = 1'b0;
        lat = 1;
        while (done_a[i] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("op%0d latency", i), 256'(lat), 256'(elat));
        check($sformatf("op%0d y", i), dut_y(i), ey);
        check($sformatf("op%0d err", i), 256'(err_a[i]), 256'(ee));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

    initial begin
        int   lat;
        res_t r;
        logic [255:0] av, bv, mv;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start_a[i] = 1'b0;
            op_a[i]    = '0;
            op_b[i]    = '0;
            op_m[i]    = '0;
        end
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset y", dut_y(0), 256'd0);
        check("reset busy", 256'(busy_a[0]), 256'd0);
        check("reset done", 256'(done_a[4]), 256'd0);
        check("reset err", 256'(err_a[4]), 256'd0);

        run_op(0, 5, 7, 11, 0, 2, 0, 4);
        run_op(0, 255, 250, 251, 0, 247, 0, 6);
        run_op(1, 255, 250, 251, 0, 247, 0, 10);
        run_op(0, 0, 9, 13, 0, 0, 0, 2);
        run_op(0, 1, 0, 3, 0, 0, 0, 3);
        run_op(0, 3, 11, 11, 0, 0, 1, 2);
        run_op(0, 3, 0, 0, 0, 0, 1, 2);
        run_op(0, 5, 7, 11, 0, 2, 0, 4);
        run_op(0, 255, 250, 251, 1, 247, 0, 6);
        run_op(0, 5, 7, 11, 1, 2, 0, 4);

        // Second start during RUN must be ignored.
        @(negedge clk);
        op_a[0] = 255; op_b[0] = 250; op_m[0] = 251; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        @(negedge clk);
        op_a[0] = 1; op_b[0] = 0; op_m[0] = 3; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        lat = 3;
        while (done_a[0] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("ignored start latency", 256'(lat), 256'd6);
        check("ignored start y", dut_y(0), 256'd247);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        op_a[0] = 255; op_b[0] = 250; op_m[0] = 251; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset y", dut_y(0), 256'd0);
        check("async reset busy", 256'(busy_a[0]), 256'd0);
        check("async reset done", 256'(done_a[0]), 256'd0);
        check("async reset err", 256'(err_a[0]), 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no done after reset", 256'(done_a[0]), 256'd0);
        end
        run_op(0, 5, 7, 11, 0, 2, 0, 4);

        for (int i = 2; i < NI; i++) begin
            for (int n = 0; n < 5; n++) begin
                mv = rand256() >> $urandom_range(0, 192);
                if (mv == '0) mv = 256'd1;
                bv = (n == 4) ? mv : (rand256() % mv);
                av = rand256() >> $urandom_range(0, 255);
                r  = ref_op(av, bv, mv, 256, inst_dg(i));
                run_op(i, av, bv, mv, 0, r.y, r.err, 2 + int'(r.k));
            end
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
